ntt_stage_ctrl: RTL and testbench



---
 rtl/ntt_stage_ctrl_pkg.sv | 25 ++
 rtl/ntt_stage_ctrl_if.sv | 40 ++++
 rtl/ntt_stage_ctrl_delay_line.sv | 25 ++
 rtl/ntt_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared types for the NTT stage sequencer: ring size, state enum and address widths.
// Ring size comes from `RING_SIZE (defaults to 8 when not supplied on the command line).
`ifndef RING_SIZE
`define RING_SIZE 8
`endif

package ntt_pkg;

  localparam int N       = `RING_SIZE;
  localparam int LOG_N   = $clog2(N);
  localparam int HALF_N  = N / 2;
  localparam int STAGE_W = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  typedef logic [LOG_N-1:0]   coef_addr_t;
  typedef logic [LOG_N-2:0]   tw_addr_t;
  typedef logic [STAGE_W-1:0] stage_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Handshake and address bus between the NTT stage sequencer and its host/datapath.
// Carries the inverse select only when NTT_INVERSE_EN is defined.
interface ntt_stage_ctrl_if;
  import ntt_pkg::*;

`ifdef NTT_INVERSE_EN
  logic       inverse;
`endif
  logic       start;
  logic       load_done;
  logic       busy;
  logic       rd_en;
  coef_addr_t rd_addr_a;
  coef_addr_t rd_addr_b;
  tw_addr_t   tw_addr;
  logic       wr_en;
  coef_addr_t wr_addr_a;
  coef_addr_t wr_addr_b;
  stage_t     stage;
  logic       done;

  modport master (
`ifdef NTT_INVERSE_EN
    input  inverse,
`endif
    input  start, load_done,
    output busy, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b, stage, done
  );

  modport slave (
`ifdef NTT_INVERSE_EN
    output inverse,
`endif
    output start, load_done,
    input  busy, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b, stage, done
  );

endinterface

// File: rtl/ntt_stage_ctrl_delay_line.sv
// Fixed-depth shift register with async clear, used to replay read addresses as write-backs.
module ntt_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Radix-2 Cooley-Tukey NTT stage sequencer: one butterfly per cycle, drain between stages.
// Optional NTT_INVERSE_EN adds an inverse input that negates twiddle exponents for the INTT.
module ntt_stage_ctrl
  import ntt_pkg::*;
#(
  parameter int BF_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  ntt_stage_ctrl_if.master    bus
);

  localparam int K_W  = LOG_N - 1;
  localparam int D_W  = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam int WB_W = 1 + 2 * LOG_N;

  typedef logic [K_W-1:0]   k_t;
  typedef logic [D_W-1:0]   drain_t;
  typedef logic [STAGE_W:0] shamt_t;

  state_t state;
  k_t     k;
  stage_t s;
  drain_t drain_cnt;
  logic   busy_q;
  logic   rd_en_q;
  logic   done_q;
`ifdef NTT_INVERSE_EN
  logic   inv_q;
`endif

  // Control FSM: walks butterflies within a stage, then idles BF_LATENCY cycles so the
  // last write of a stage retires before the next stage reads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      s         <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef NTT_INVERSE_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && bus.load_done) begin
            state   <= ISSUE;
            k       <= '0;
            s       <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
`ifdef NTT_INVERSE_EN
            inv_q   <= bus.inverse;
`endif
          end
        end
        ISSUE: begin
          if (k == k_t'(HALF_N - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            rd_en_q   <= 1'b0;
          end else begin
            k <= k + k_t'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == drain_t'(BF_LATENCY - 1)) begin
            if (s == stage_t'(LOG_N - 1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= ISSUE;
              s       <= s + stage_t'(1);
              k       <= '0;
              rd_en_q <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + drain_t'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          s      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  coef_addr_t k_ext, half, pos, grp, addr_a, addr_b, tw_full;
  coef_addr_t rd_a, rd_b;
  tw_addr_t   tw_idx, tw_out;
  shamt_t     s_ext;

  // Address generation from the registered butterfly index and stage; zeroed when not reading.
  always_comb begin
    s_ext   = {1'b0, s};
    k_ext   = coef_addr_t'(k);
    half    = coef_addr_t'(1) << s;
    pos     = k_ext & (half - coef_addr_t'(1));
    grp     = k_ext >> s;
    addr_a  = (grp << (s_ext + shamt_t'(1))) | pos;
    addr_b  = addr_a + half;
    tw_full = pos << (shamt_t'(LOG_N - 1) - s_ext);
    tw_idx  = tw_addr_t'(tw_full);
`ifdef NTT_INVERSE_EN
    if (inv_q) tw_idx = tw_addr_t'(0) - tw_idx;
`endif
    rd_a   = rd_en_q ? addr_a : '0;
    rd_b   = rd_en_q ? addr_b : '0;
    tw_out = rd_en_q ? tw_idx : '0;
  end

  logic [WB_W-1:0] wb_q;

  ntt_delay_line #(
    .WIDTH (WB_W),
    .DEPTH (BF_LATENCY)
  ) u_wb_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({rd_en_q, rd_a, rd_b}),
    .q     (wb_q)
  );

  assign bus.busy      = busy_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a;
  assign bus.rd_addr_b = rd_b;
  assign bus.tw_addr   = tw_out;
  assign bus.wr_en     = wb_q[WB_W-1];
  assign bus.wr_addr_a = wb_q[2*LOG_N-1:LOG_N];
  assign bus.wr_addr_b = wb_q[LOG_N-1:0];
  assign bus.stage     = s;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Randomized bench for ntt_stage_ctrl against a per-cycle schedule built from butterfly arithmetic.
module tb_ntt_stage_ctrl;
  import ntt_pkg::*;

  localparam int L     = 2;
  localparam int TOTAL = LOG_N * (HALF_N + L) + 1;
  localparam int MAXC  = TOTAL + 4;

  logic clk;
  logic reset;

  ntt_stage_ctrl_if bus();

  ntt_stage_ctrl #(.BF_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int cur_cycle   = 0;

  int m_busy [MAXC];
  int m_rd   [MAXC];
  int m_a    [MAXC];
  int m_b    [MAXC];
  int m_tw   [MAXC];
  int m_wr   [MAXC];
  int m_wa   [MAXC];
  int m_wb   [MAXC];
  int m_stg  [MAXC];
  int m_done [MAXC];

  task automatic check_output(input string tag, input int obs, input int exp);
    check_count++;
    if (obs == exp) pass_count++;
    else $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", tag, cur_cycle, obs, exp);
  endtask

  // Expected schedule: cycle 0 is the accept cycle, butterflies in natural order per stage.
  task automatic build_model(input bit inv);
    int c, half, pos, idx;
    for (int i = 0; i < MAXC; i++) begin
      m_busy[i] = 0; m_rd[i] = 0; m_a[i] = 0; m_b[i] = 0; m_tw[i] = 0;
      m_wr[i] = 0; m_wa[i] = 0; m_wb[i] = 0; m_stg[i] = 0; m_done[i] = 0;
    end
    c = 1;
    for (int st = 0; st < LOG_N; st++) begin
      half = 2 ** st;
      for (int kk = 0; kk < HALF_N; kk++) begin
        pos       = kk % half;
        idx       = pos * (HALF_N / half);
        m_rd[c]   = 1;
        m_a[c]    = (kk / half) * 2 * half + pos;
        m_b[c]    = m_a[c] + half;
        m_tw[c]   = inv ? (HALF_N - idx) % HALF_N : idx;
        m_busy[c] = 1;
        m_stg[c]  = st;
        c++;
      end
      for (int d = 0; d < L; d++) begin
        m_busy[c] = 1;
        m_stg[c]  = st;
        c++;
      end
    end
    m_done[c] = 1;
    m_busy[c] = 1;
    m_stg[c]  = LOG_N - 1;
    for (int i = L; i < MAXC; i++) begin
      m_wr[i] = m_rd[i-L];
      m_wa[i] = m_a[i-L];
      m_wb[i] = m_b[i-L];
    end
  endtask

  task automatic check_cycle(input int c);
    check_output("busy",   int'(bus.busy),      m_busy[c]);
    check_output("rd_en",  int'(bus.rd_en),     m_rd[c]);
    check_output("rd_a",   int'(bus.rd_addr_a), m_a[c]);
    check_output("rd_b",   int'(bus.rd_addr_b), m_b[c]);
    check_output("tw",     int'(bus.tw_addr),   m_tw[c]);
    check_output("wr_en",  int'(bus.wr_en),     m_wr[c]);
    check_output("wr_a",   int'(bus.wr_addr_a), m_wa[c]);
    check_output("wr_b",   int'(bus.wr_addr_b), m_wb[c]);
    check_output("stage",  int'(bus.stage),     m_stg[c]);
    check_output("done",   int'(bus.done),      m_done[c]);
  endtask

  task automatic check_zero(input string tag);
    int all;
    all = int'(bus.busy) + int'(bus.rd_en) + int'(bus.rd_addr_a) + int'(bus.rd_addr_b)
        + int'(bus.tw_addr) + int'(bus.wr_en) + int'(bus.wr_addr_a) + int'(bus.wr_addr_b)
        + int'(bus.stage) + int'(bus.done);
    check_output(tag, all, 0);
  endtask

  task automatic apply_stimulus(input bit st, input bit ld, input bit inv);
    bus.start     = st;
    bus.load_done = ld;
`ifdef NTT_INVERSE_EN
    bus.inverse   = inv;
`else
    if (inv) bus.start = st;
`endif
  endtask

  // One transform; random start/load_done noise while busy. reset_cycle<0 means no abort.
  task automatic run_transform(input int reset_cycle, input bit inv);
    build_model(inv);
    for (int c = 0; c <= TOTAL + 2; c++) begin
      @(posedge clk);
      #1;
      cur_cycle = c;
      if (c == 0)          apply_stimulus(1'b1, 1'b1, inv);
      else if (c == 8)     apply_stimulus(1'b1, 1'b1, 1'($urandom));
      else if (c <= TOTAL) apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom));
      else                 apply_stimulus(1'b0, 1'($urandom), 1'($urandom));
      if (c == reset_cycle) begin
        #1;
        bus.start = 1'b0;
        reset = 1'b1;
        #1;
        check_zero("abort_zero");
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < L + 4; j++) begin
          @(negedge clk);
          cur_cycle = c + 1 + j;
          check_output("abort_wr_en", int'(bus.wr_en), 0);
          check_output("abort_done",  int'(bus.done),  0);
          check_output("abort_busy",  int'(bus.busy),  0);
        end
        return;
      end
      @(negedge clk);
      check_cycle(c);
    end
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    #12;
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      apply_stimulus(1'($urandom), 1'b0, 1'($urandom));
      @(negedge clk);
      cur_cycle = i;
      check_output("idle_busy",  int'(bus.busy),  0);
      check_output("idle_rd_en", int'(bus.rd_en), 0);
      check_output("idle_stage", int'(bus.stage), 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);

    run_transform(-1, 1'b0);
    run_transform(8, 1'b0);
    run_transform(-1, 1'b0);
`ifdef NTT_INVERSE_EN
    run_transform(-1, 1'b1);
    run_transform(-1, 1'($urandom));
`endif
    run_transform($urandom_range(1, TOTAL), 1'b0);
    run_transform(-1, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
